// File: rtl/mat_stream_reader.sv
// Frame read sequencer: walks a rows x cols window of the Mats RAM and streams pixels over valid/ready.
// Optional MAT_READER_EOL_EN adds a per-pixel end-of-row tag (m_eol).
module mat_stream_reader #(
  parameter int ADDR_WITH = 8,
  parameter int DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_WITH-1:0] base_addr,
  input  logic [7:0]           cols,
  input  logic [7:0]           rows,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_WITH-1:0] mem_addr,
  output logic                 mem_oe,
  output logic                 mem_we,
  input  logic [DATA_W-1:0]    mem_rd_q,
  output logic [DATA_W-1:0]    m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last
`ifdef MAT_READER_EOL_EN
  , output logic               m_eol
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WITH-1:0]   cursor_q, cursor_d;
  logic [15:0]            issuedCnt_q, issuedCnt_d;
  logic [15:0]            totalPix_q, totalPix_d;
  logic                   inFlight_q, inFlight_d;
  logic                   inFlightLast_q, inFlightLast_d;
  logic [1:0]             fifoOcc_q, fifoOcc_d;
  logic [DATA_W-1:0]      headData_q, headData_d, tailData_q, tailData_d;
  logic                   headLast_q, headLast_d, tailLast_q, tailLast_d;
  logic                   issue, issueLast, push, pop, slotFree;
`ifdef MAT_READER_EOL_EN
  logic [7:0]             colsLat_q, colsLat_d, colCnt_q, colCnt_d;
  logic                   inFlightEol_q, inFlightEol_d;
  logic                   headEol_q, headEol_d, tailEol_q, tailEol_d;
  logic                   issueEol;
`endif

  assign m_valid  = (fifoOcc_q != 2'd0);
  assign pop      = m_valid & m_ready;
  assign push     = inFlight_q;
  assign slotFree = (({1'b0, fifoOcc_q} + {2'b00, inFlight_q}) < 3'd2) || pop;
  assign m_data   = headData_q;
  assign m_last   = m_valid & headLast_q;
  assign mem_oe   = issue;
  assign mem_addr = cursor_q;
  assign mem_we   = 1'b0;
`ifdef MAT_READER_EOL_EN
  assign m_eol    = m_valid & headEol_q;
`endif

  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    issuedCnt_d = issuedCnt_q;
    totalPix_d  = totalPix_q;
    issue       = 1'b0;
    issueLast   = 1'b0;
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
`ifdef MAT_READER_EOL_EN
    colsLat_d   = colsLat_q;
    colCnt_d    = colCnt_q;
    issueEol    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          cursor_d    = base_addr;
          issuedCnt_d = 16'd0;
          totalPix_d  = {8'd0, rows} * {8'd0, cols};
          state_d     = RUN;
`ifdef MAT_READER_EOL_EN
          colsLat_d   = cols;
          colCnt_d    = 8'd0;
`endif
        end
      end
      // An empty frame spends one cycle in RUN without reading, so done lands two cycles after start.
      RUN: begin
        if (totalPix_q == 16'd0) begin
          state_d = DONE;
        end else if (slotFree) begin
          issue       = 1'b1;
          issueLast   = (issuedCnt_q == totalPix_q - 16'd1);
          cursor_d    = cursor_q + ADDR_WITH'(1);
          issuedCnt_d = issuedCnt_q + 16'd1;
          if (issueLast) state_d = DRAIN;
`ifdef MAT_READER_EOL_EN
          issueEol = (colCnt_q == colsLat_q - 8'd1);
          colCnt_d = issueEol ? 8'd0 : colCnt_q + 8'd1;
`endif
        end
      end
      DRAIN: begin
        if (pop && headLast_q && fifoOcc_q == 2'd1 && !inFlight_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inFlight_d     = issue;
    inFlightLast_d = issueLast;
    fifoOcc_d      = fifoOcc_q;
    headData_d     = headData_q;
    tailData_d     = tailData_q;
    headLast_d     = headLast_q;
    tailLast_d     = tailLast_q;
`ifdef MAT_READER_EOL_EN
    inFlightEol_d  = issueEol;
    headEol_d      = headEol_q;
    tailEol_d      = tailEol_q;
`endif
    case ({push, pop})
      2'b10: begin
        fifoOcc_d = fifoOcc_q + 2'd1;
        if (fifoOcc_q == 2'd0) begin
          headData_d = mem_rd_q;
          headLast_d = inFlightLast_q;
`ifdef MAT_READER_EOL_EN
          headEol_d  = inFlightEol_q;
`endif
        end else begin
          tailData_d = mem_rd_q;
          tailLast_d = inFlightLast_q;
`ifdef MAT_READER_EOL_EN
          tailEol_d  = inFlightEol_q;
`endif
        end
      end
      2'b01: begin
        fifoOcc_d  = fifoOcc_q - 2'd1;
        headData_d = tailData_q;
        headLast_d = tailLast_q;
`ifdef MAT_READER_EOL_EN
        headEol_d  = tailEol_q;
`endif
      end
      // Simultaneous push and pop: the incoming pixel lands behind whatever remains.
      2'b11: begin
        if (fifoOcc_q == 2'd1) begin
          headData_d = mem_rd_q;
          headLast_d = inFlightLast_q;
`ifdef MAT_READER_EOL_EN
          headEol_d  = inFlightEol_q;
`endif
        end else begin
          headData_d = tailData_q;
          headLast_d = tailLast_q;
          tailData_d = mem_rd_q;
          tailLast_d = inFlightLast_q;
`ifdef MAT_READER_EOL_EN
          headEol_d  = tailEol_q;
          tailEol_d  = inFlightEol_q;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cursor_q       <= '0;
      issuedCnt_q    <= '0;
      totalPix_q     <= '0;
      inFlight_q     <= 1'b0;
      inFlightLast_q <= 1'b0;
      fifoOcc_q      <= '0;
      headData_q     <= '0;
      tailData_q     <= '0;
      headLast_q     <= 1'b0;
      tailLast_q     <= 1'b0;
`ifdef MAT_READER_EOL_EN
      colsLat_q      <= '0;
      colCnt_q       <= '0;
      inFlightEol_q  <= 1'b0;
      headEol_q      <= 1'b0;
      tailEol_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cursor_q       <= cursor_d;
      issuedCnt_q    <= issuedCnt_d;
      totalPix_q     <= totalPix_d;
      inFlight_q     <= inFlight_d;
      inFlightLast_q <= inFlightLast_d;
      fifoOcc_q      <= fifoOcc_d;
      headData_q     <= headData_d;
      tailData_q     <= tailData_d;
      headLast_q     <= headLast_d;
      tailLast_q     <= tailLast_d;
`ifdef MAT_READER_EOL_EN
      colsLat_q      <= colsLat_d;
      colCnt_q       <= colCnt_d;
      inFlightEol_q  <= inFlightEol_d;
      headEol_q      <= headEol_d;
      tailEol_q      <= tailEol_d;
`endif
    end
  end

  // The credit scheme must never let a returning pixel hit a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst && push && !pop) assert (fifoOcc_q != 2'd2);
  end

endmodule

// File: tb/tb_mat_stream_reader.sv
// Directed self-checking bench for mat_stream_reader against a 1-cycle-latency RAM model.
module tb_mat_stream_reader;

  logic       clk = 1'b0;
  logic       rst, start, m_ready;
  logic [7:0] base_addr, cols, rows;
  logic       busy, done, mem_oe, mem_we, m_valid, m_last;
  logic [7:0] mem_addr, mem_rd_q, m_data;
`ifdef MAT_READER_EOL_EN
  logic       m_eol;
`endif
  int nChecks = 0;
  int nBad    = 0;

  always #5 clk = ~clk;

  mat_stream_reader #(.ADDR_WITH(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .cols(cols), .rows(rows), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_oe(mem_oe), .mem_we(mem_we), .mem_rd_q(mem_rd_q),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
`ifdef MAT_READER_EOL_EN
    , .m_eol(m_eol)
`endif
  );

  // RAM holds its own address at every location; garbage is returned when not enabled.
  always @(posedge clk) mem_rd_q <= mem_oe ? mem_addr : 8'hEE;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drives start for cycle T and returns settled inside cycle T+1.
  task automatic applyStimulus(input logic [7:0] b, input logic [7:0] r, input logic [7:0] c);
    nextCycle();
    start = 1'b1; base_addr = b; rows = r; cols = c;
    #1;
    checkOutput("idle_busy", busy, 1'b0);
    nextCycle();
    start = 1'b0; base_addr = 8'h00; rows = 8'h00; cols = 8'h00;
    #1;
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_busy"}, busy, 1'b0);
    checkOutput({pfx, "_done"}, done, 1'b0);
    checkOutput({pfx, "_oe"}, mem_oe, 1'b0);
    checkOutput({pfx, "_we"}, mem_we, 1'b0);
    checkOutput({pfx, "_addr"}, mem_addr, 8'h00);
    checkOutput({pfx, "_valid"}, m_valid, 1'b0);
    checkOutput({pfx, "_data"}, m_data, 8'h00);
    checkOutput({pfx, "_last"}, m_last, 1'b0);
  endtask

  // Full-rate frame with m_ready held high: exact cycle-by-cycle expectations.
  task automatic runStreaming(input logic [7:0] b, input logic [7:0] r, input logic [7:0] c);
    int total;
    logic [7:0] expData;
    total = int'(r) * int'(c);
    m_ready = 1'b1;
    applyStimulus(b, r, c);
    checkOutput("t1_oe", mem_oe, 1'b1);
    checkOutput("t1_addr", mem_addr, b);
    checkOutput("t1_busy", busy, 1'b1);
    nextCycle();
    checkOutput("t2_valid", m_valid, 1'b0);
    for (int i = 0; i < total; i++) begin
      nextCycle();
      expData = b + 8'(i);
      checkOutput("beat_valid", m_valid, 1'b1);
      checkOutput("beat_data", m_data, expData);
      checkOutput("beat_last", m_last, (i == total - 1));
`ifdef MAT_READER_EOL_EN
      checkOutput("beat_eol", m_eol, ((i % int'(c)) == int'(c) - 1));
`endif
    end
    nextCycle();
    checkOutput("end_done", done, 1'b1);
    checkOutput("end_valid", m_valid, 1'b0);
    nextCycle();
    checkOutput("after_done", done, 1'b0);
    checkOutput("after_busy", busy, 1'b0);
  endtask

  task automatic runBackPressure();
    logic       pattern [4];
    int         issued, popped;
    logic       stallPending, doneSeen;
    logic [7:0] heldData;
    pattern = '{1'b1, 1'b0, 1'b0, 1'b1};
    issued = 0; popped = 0; stallPending = 1'b0; doneSeen = 1'b0; heldData = 8'h00;
    m_ready = 1'b1;
    applyStimulus(8'h40, 8'd2, 8'd4);
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc != 0) nextCycle();
      m_ready = pattern[cyc % 4];
      #1;
      if (stallPending) begin
        checkOutput("bp_hold_valid", m_valid, 1'b1);
        checkOutput("bp_hold_data", m_data, heldData);
      end
      if (mem_oe) begin
        checkOutput("bp_addr", mem_addr, 8'h40 + 8'(issued));
        issued++;
        checkOutput("bp_outstanding", ((issued - popped - int'(m_valid & m_ready)) <= 2), 1'b1);
      end
      if (m_valid && m_ready) begin
        checkOutput("bp_data", m_data, 8'h40 + 8'(popped));
        checkOutput("bp_last", m_last, (popped == 7));
        popped++;
      end
      stallPending = m_valid & ~m_ready;
      heldData     = m_data;
      if (done) begin
        doneSeen = 1'b1;
        break;
      end
    end
    checkOutput("bp_done_seen", doneSeen, 1'b1);
    checkOutput("bp_popped", popped, 8);
    checkOutput("bp_issued", issued, 8);
    m_ready = 1'b1;
    nextCycle();
    checkOutput("bp_idle", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; m_ready = 1'b1;
    base_addr = 8'h00; rows = 8'h00; cols = 8'h00;
    repeat (3) nextCycle();
    checkResetValues("rst");
    rst = 1'b0;

    $display("[TB] basic frame");
    runStreaming(8'h10, 8'd2, 8'd3);

    $display("[TB] wrap-around");
    runStreaming(8'hFE, 8'd1, 8'd4);

    $display("[TB] back-pressure");
    runBackPressure();

    $display("[TB] empty frame");
    applyStimulus(8'h20, 8'd0, 8'd5);
    checkOutput("empty_t1_oe", mem_oe, 1'b0);
    checkOutput("empty_t1_valid", m_valid, 1'b0);
    checkOutput("empty_t1_busy", busy, 1'b1);
    checkOutput("empty_t1_done", done, 1'b0);
    nextCycle();
    checkOutput("empty_t2_done", done, 1'b1);
    checkOutput("empty_t2_oe", mem_oe, 1'b0);
    checkOutput("empty_t2_valid", m_valid, 1'b0);
    nextCycle();
    checkOutput("empty_t3_done", done, 1'b0);
    checkOutput("empty_t3_busy", busy, 1'b0);

    $display("[TB] reset mid-frame");
    applyStimulus(8'h80, 8'd4, 8'd4);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("mid_data", m_data, 8'h80 + 8'(i));
    end
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    #1;
    checkResetValues("midrst");
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("midrst_no_valid", m_valid, 1'b0);
      checkOutput("midrst_no_oe", mem_oe, 1'b0);
    end
    runStreaming(8'h80, 8'd4, 8'd4);

    $display("[TB] 3x2 frame");
    runStreaming(8'h30, 8'd3, 8'd2);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
